inst_fetch_unit: RTL and testbench

//  IF-stage reader for the PC register: fetches the instruction at i_pc from instruction

---
 rtl/inst_fetch_unit.sv | 133 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// IF-stage fetch unit: requests instructions at i_pc over a req/gnt/rvalid bus and
// hands returned words, tagged with their PCs, to decode in program order.
module inst_fetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc,
  output logic        o_pc_write,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

  logic [31:0]      r_pc_q   [DEPTH];
  logic [31:0]      r_inst_q [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_fill;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_unfilled;
  logic [CW-1:0] r_drop;
  logic          r_run;
  logic          r_err;

  logic [CW:0]   w_inflight;
  logic          w_req;
  logic          w_grant;
  logic          w_drop_nz;
  logic          w_has_unfilled;
  logic          w_drop_resp;
  logic          w_fill;
  logic          w_orphan;
  logic          w_valid;
  logic          w_pop;
  logic [CW-1:0] w_drop_flush;

  // Allocated entries plus responses still owed to a flushed stream bound the bus occupancy.
  assign w_inflight     = {1'b0, r_count} + {1'b0, r_drop};
  assign w_req          = r_run & ~i_flush & (w_inflight < LP_DEPTH);
  assign w_grant        = w_req & i_mem_gnt;
  assign w_drop_nz      = (r_drop != '0);
  assign w_has_unfilled = (r_unfilled != '0);
  assign w_drop_resp    = i_mem_rvalid & w_drop_nz;
  assign w_fill         = i_mem_rvalid & ~w_drop_nz & w_has_unfilled & ~i_flush;
  assign w_orphan       = i_mem_rvalid & ~w_drop_nz & ~w_has_unfilled;
  assign w_valid        = (r_count != '0) & r_filled[r_rd] & ~i_flush;
  assign w_pop          = w_valid & i_inst_ready;

  // A response arriving in the flush cycle consumes one of the owed slots immediately.
  assign w_drop_flush = r_drop + r_unfilled
                      - CW'(i_mem_rvalid & (w_drop_nz | w_has_unfilled));

  assign o_mem_req    = w_req;
  assign o_mem_addr   = i_pc;
  assign o_pc_write   = i_flush | w_grant;
  assign o_inst_valid = w_valid;
  assign o_inst       = r_inst_q[r_rd];
  assign o_inst_pc    = r_pc_q[r_rd];
  assign o_err        = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]   <= '0;
        r_inst_q[i] <= '0;
      end
      r_filled <= '0;
    end else begin
      if (w_grant) begin
        r_pc_q[r_wr]   <= i_pc;
        r_filled[r_wr] <= 1'b0;
      end
      if (w_fill) begin
        r_inst_q[r_fill] <= i_mem_rdata;
        r_filled[r_fill] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr       <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_drop     <= '0;
      r_run      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_orphan) begin
        r_err <= 1'b1;
      end
      if (i_flush) begin
        r_count    <= '0;
        r_unfilled <= '0;
        r_rd       <= r_wr;
        r_fill     <= r_wr;
        r_drop     <= w_drop_flush;
      end else begin
        r_count    <= r_count + CW'(w_grant) - CW'(w_pop);
        r_unfilled <= r_unfilled + CW'(w_grant) - CW'(w_fill);
        r_drop     <= r_drop - CW'(w_drop_resp);
        if (w_grant) begin
          r_wr <= r_wr + AW'(1);
        end
        if (w_fill) begin
          r_fill <= r_fill + AW'(1);
        end
        if (w_pop) begin
          r_rd <= r_rd + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: each step drives one cycle of bus/decode inputs
// and compares outputs against hand-derived values.
module tb_inst_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] iPc;
  logic        pcWrite;
  logic        flush;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        instValid;
  logic [31:0] inst;
  logic [31:0] instPc;
  logic        instReady;
  logic        err;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_pc         (iPc),
    .o_pc_write   (pcWrite),
    .i_flush      (flush),
    .o_mem_req    (memReq),
    .o_mem_addr   (memAddr),
    .i_mem_gnt    (memGnt),
    .i_mem_rvalid (memRvalid),
    .i_mem_rdata  (memRdata),
    .o_inst_valid (instValid),
    .o_inst       (inst),
    .o_inst_pc    (instPc),
    .i_inst_ready (instReady),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle and drive that cycle's inputs well clear of the edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic fl, input logic gnt,
                               input logic rv, input logic [31:0] rdata, input logic rdy);
    @(posedge clk);
    #1;
    iPc       = pc;
    flush     = fl;
    memGnt    = gnt;
    memRvalid = rv;
    memRdata  = rdata;
    instReady = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  initial begin
    reset     = 1'b0;
    iPc       = '0;
    flush     = 1'b0;
    memGnt    = 1'b0;
    memRvalid = 1'b0;
    memRdata  = '0;
    instReady = 1'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("rst_req",    32'(memReq),    32'd0);
    checkOutput("rst_valid",  32'(instValid), 32'd0);
    checkOutput("rst_err",    32'(err),       32'd0);
    checkOutput("rst_pcw",    32'(pcWrite),   32'd0);
    checkOutput("rst_inst",   inst,           32'd0);
    checkOutput("rst_instpc", instPc,         32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_req_low", 32'(memReq), 32'd0);

    // Sequential fetch, one instruction per cycle
    applyStimulus(32'h0, 0, 1, 0, 32'h0, 1);
    checkOutput("t1_req_rise", 32'(memReq),  32'd1);
    checkOutput("t1_pcw",      32'(pcWrite), 32'd1);
    checkOutput("t1_addr",     memAddr,      32'h0);
    applyStimulus(32'h4, 0, 1, 1, 32'hA000_0000, 1);
    checkOutput("t1_no_bypass", 32'(instValid), 32'd0);
    applyStimulus(32'h8, 0, 1, 1, 32'hA000_0004, 1);
    checkOutput("t1_v0",   32'(instValid), 32'd1);
    checkOutput("t1_pc0",  instPc,         32'h0);
    checkOutput("t1_ins0", inst,           32'hA000_0000);
    applyStimulus(32'hC, 0, 1, 1, 32'hA000_0008, 1);
    checkOutput("t1_pc4", instPc, 32'h4);
    applyStimulus(32'h10, 0, 0, 1, 32'hA000_000C, 1);
    checkOutput("t1_nognt_pcw", 32'(pcWrite), 32'd0);
    checkOutput("t1_pc8",       instPc,       32'h8);
    applyStimulus(32'h10, 0, 0, 0, 32'h0, 1);
    checkOutput("t1_pcC",  instPc, 32'hC);
    checkOutput("t1_insC", inst,   32'hA000_000C);
    applyStimulus(32'h10, 0, 0, 0, 32'h0, 1);
    checkOutput("t1_empty", 32'(instValid), 32'd0);

    // Full queue stalls the PC, pops release it
    applyStimulus(32'h0, 0, 1, 0, 32'h0, 0);
    applyStimulus(32'h4, 0, 1, 1, 32'hA000_0000, 0);
    applyStimulus(32'h8, 0, 1, 1, 32'hA000_0004, 0);
    applyStimulus(32'hC, 0, 1, 1, 32'hA000_0008, 0);
    checkOutput("t2_4th_req", 32'(memReq), 32'd1);
    applyStimulus(32'h10, 0, 1, 1, 32'hA000_000C, 0);
    checkOutput("t2_full_req", 32'(memReq),    32'd0);
    checkOutput("t2_full_pcw", 32'(pcWrite),   32'd0);
    checkOutput("t2_head_v",   32'(instValid), 32'd1);
    checkOutput("t2_head_pc",  instPc,         32'h0);
    applyStimulus(32'h10, 0, 1, 0, 32'h0, 0);
    checkOutput("t2_still_full", 32'(memReq), 32'd0);
    applyStimulus(32'h10, 0, 1, 0, 32'h0, 1);
    checkOutput("t2_pop_cycle_req", 32'(memReq), 32'd0);
    checkOutput("t2_pop0",          instPc,      32'h0);
    applyStimulus(32'h10, 0, 1, 0, 32'h0, 1);
    checkOutput("t2_resume_req", 32'(memReq),  32'd1);
    checkOutput("t2_resume_pcw", 32'(pcWrite), 32'd1);
    checkOutput("t2_pop4",       instPc,       32'h4);
    applyStimulus(32'h14, 0, 0, 1, 32'hA000_0010, 1);
    checkOutput("t2_pop8", instPc, 32'h8);
    applyStimulus(32'h14, 0, 0, 0, 32'h0, 1);
    checkOutput("t2_popC", instPc, 32'hC);
    applyStimulus(32'h14, 0, 0, 0, 32'h0, 1);
    checkOutput("t2_pop10",  instPc, 32'h10);
    checkOutput("t2_ins10",  inst,   32'hA000_0010);
    applyStimulus(32'h14, 0, 0, 0, 32'h0, 1);
    checkOutput("t2_empty", 32'(instValid), 32'd0);

    // Flush with three fetches outstanding
    applyStimulus(32'h0, 0, 1, 0, 32'h0, 1);
    applyStimulus(32'h4, 0, 1, 0, 32'h0, 1);
    applyStimulus(32'h8, 0, 1, 0, 32'h0, 1);
    applyStimulus(32'h100, 1, 1, 0, 32'h0, 1);
    checkOutput("t3_flush_pcw", 32'(pcWrite),   32'd1);
    checkOutput("t3_flush_req", 32'(memReq),    32'd0);
    checkOutput("t3_flush_v",   32'(instValid), 32'd0);
    applyStimulus(32'h100, 0, 1, 0, 32'h0, 1);
    checkOutput("t3_refetch_req", 32'(memReq), 32'd1);
    applyStimulus(32'h104, 0, 1, 1, 32'hEEEE_0000, 1);
    checkOutput("t3_drop3_full", 32'(memReq),    32'd0);
    checkOutput("t3_drop_v0",    32'(instValid), 32'd0);
    applyStimulus(32'h104, 0, 1, 1, 32'hEEEE_0004, 1);
    checkOutput("t3_req_again", 32'(memReq), 32'd1);
    applyStimulus(32'h108, 0, 0, 1, 32'hEEEE_0008, 1);
    checkOutput("t3_drop_v2", 32'(instValid), 32'd0);
    applyStimulus(32'h108, 0, 0, 1, 32'hB000_0100, 1);
    checkOutput("t3_fill_hidden", 32'(instValid), 32'd0);
    applyStimulus(32'h108, 0, 0, 1, 32'hB000_0104, 1);
    checkOutput("t3_first_v",  32'(instValid), 32'd1);
    checkOutput("t3_first_pc", instPc,         32'h100);
    checkOutput("t3_first_in", inst,           32'hB000_0100);
    applyStimulus(32'h108, 0, 0, 0, 32'h0, 1);
    checkOutput("t3_second_pc", instPc, 32'h104);
    checkOutput("t3_second_in", inst,   32'hB000_0104);
    applyStimulus(32'h108, 0, 0, 0, 32'h0, 1);
    checkOutput("t3_empty", 32'(instValid), 32'd0);
    checkOutput("t3_err",   32'(err),       32'd0);

    // Flush coinciding with a response, two unfilled
    applyStimulus(32'h200, 0, 1, 0, 32'h0, 1);
    applyStimulus(32'h204, 0, 1, 0, 32'h0, 1);
    applyStimulus(32'h300, 1, 0, 1, 32'hEEEE_0200, 1);
    checkOutput("t4_flush_pcw", 32'(pcWrite),   32'd1);
    checkOutput("t4_flush_v",   32'(instValid), 32'd0);
    applyStimulus(32'h300, 0, 1, 0, 32'h0, 1);
    checkOutput("t4_req", 32'(memReq), 32'd1);
    applyStimulus(32'h304, 0, 0, 1, 32'hEEEE_0204, 1);
    applyStimulus(32'h304, 0, 0, 1, 32'hC000_0300, 1);
    checkOutput("t4_one_dropped", 32'(instValid), 32'd0);
    applyStimulus(32'h304, 0, 0, 0, 32'h0, 1);
    checkOutput("t4_v",   32'(instValid), 32'd1);
    checkOutput("t4_pc",  instPc,         32'h300);
    checkOutput("t4_ins", inst,           32'hC000_0300);
    applyStimulus(32'h304, 0, 0, 0, 32'h0, 1);
    checkOutput("t4_empty", 32'(instValid), 32'd0);
    checkOutput("t4_err",   32'(err),       32'd0);

    // Grant, fill and pop together at count=2
    applyStimulus(32'h400, 0, 1, 0, 32'h0, 0);
    applyStimulus(32'h404, 0, 1, 1, 32'hD000_0400, 0);
    applyStimulus(32'h408, 0, 1, 1, 32'hD000_0404, 1);
    checkOutput("t5_pcw", 32'(pcWrite),   32'd1);
    checkOutput("t5_v",   32'(instValid), 32'd1);
    checkOutput("t5_pc",  instPc,         32'h400);
    applyStimulus(32'h40C, 0, 0, 1, 32'hD000_0408, 0);
    checkOutput("t5_req_cnt2", 32'(memReq), 32'd1);
    checkOutput("t5_pc2",      instPc,      32'h404);
    checkOutput("t5_in2",      inst,        32'hD000_0404);
    applyStimulus(32'h40C, 0, 0, 0, 32'h0, 1);
    checkOutput("t5_pc2_pop", instPc, 32'h404);
    applyStimulus(32'h40C, 0, 0, 0, 32'h0, 1);
    checkOutput("t5_pc3", instPc, 32'h408);
    checkOutput("t5_in3", inst,   32'hD000_0408);
    applyStimulus(32'h40C, 0, 0, 0, 32'h0, 1);
    checkOutput("t5_empty", 32'(instValid), 32'd0);

    // Unexpected response sets a sticky error
    applyStimulus(32'h40C, 0, 0, 1, 32'hDEAD_BEEF, 1);
    checkOutput("t6_err_pre", 32'(err), 32'd0);
    applyStimulus(32'h40C, 0, 0, 0, 32'h0, 1);
    checkOutput("t6_err",   32'(err),       32'd1);
    checkOutput("t6_no_v",  32'(instValid), 32'd0);
    applyStimulus(32'h40C, 0, 0, 0, 32'h0, 1);
    applyStimulus(32'h40C, 0, 0, 0, 32'h0, 1);
    checkOutput("t6_sticky", 32'(err), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_err", 32'(err),    32'd0);
    checkOutput("t6_rst_req", 32'(memReq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
